glitch_filter_scan: RTL and testbench

Multi-channel glitch filter that time-shares one up/down filter engine across N input pins using a round-robin scan. Per-channel counter and state live in registers. The engine updates one channel per enabled cycle. Rise/fall events are queued in a small FIFO and leave through a valid/ready port. It sits between slow board inputs (buttons, presence-detect, open-drain status lines) and a CSR/IRQ block, replacing N separate filter instances.

---
 rtl/glitch_filter_scan.sv | 146 ++++++++++++++
 tb/tb_glitch_filter_scan.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glitch_filter_scan.sv
// Multi-channel glitch filter: one saturating up/down engine time-shared across N pins
// by a round-robin scan, with rise/fall events queued in a small FIFO.
module glitch_filter_scan #(
    parameter int N          = 8,
    parameter int L          = 4,
    parameter int FIFO_DEPTH = 4,
    localparam int CW        = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  pin_iob_reg,
    input  logic          en,
    input  logic [N-1:0]  mask,
    output logic [N-1:0]  val,
    output logic          evt_valid,
    input  logic          evt_ready,
    output logic [CW-1:0] evt_chan,
    output logic          evt_rise,
    output logic          ovf,
    input  logic          ovf_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [L-1:0] CNT_MAX = '1;

    logic [N-1:0]  sync1_reg;
    logic [N-1:0]  sync2_reg;
    logic [CW-1:0] ptr_reg;
    logic [N-1:0]  rise_vec;
    logic [N-1:0]  fall_vec;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          drop;
    logic          fifo_full;
    logic          evt_is_rise;
    logic          ovf_reg;

    logic [CW:0]   mem_reg [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= '1;
            sync2_reg <= '1;
        end else begin
            sync1_reg <= pin_iob_reg;
            sync2_reg <= sync1_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= '0;
        end else if (en) begin
            ptr_reg <= (ptr_reg == CW'(N - 1)) ? '0 : ptr_reg + 1'b1;
        end
    end

    // Each channel keeps its own counter/state; only the channel under the pointer moves.
    for (genvar gi = 0; gi < N; gi++) begin : g_chan
        logic [L-1:0] cnt_reg;
        logic [L-1:0] cnt_next;
        logic         state_reg;
        logic         visit;

        assign visit = en && (ptr_reg == CW'(gi));

        always_comb begin
            cnt_next = cnt_reg;
            if (sync2_reg[gi] && (cnt_reg != CNT_MAX)) begin
                cnt_next = cnt_reg + 1'b1;
            end else if (!sync2_reg[gi] && (cnt_reg != '0)) begin
                cnt_next = cnt_reg - 1'b1;
            end
        end

        assign rise_vec[gi] = visit && !state_reg && (cnt_next == CNT_MAX);
        assign fall_vec[gi] = visit && state_reg && (cnt_next == '0);
        assign val[gi]      = state_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_reg   <= CNT_MAX;
                state_reg <= 1'b1;
            end else if (visit) begin
                cnt_reg <= cnt_next;
                if (rise_vec[gi]) begin
                    state_reg <= 1'b1;
                end else if (fall_vec[gi]) begin
                    state_reg <= 1'b0;
                end
            end
        end
    end

    // At most one channel is visited per cycle, so OR-reductions pick its event.
    assign push_req    = |((rise_vec | fall_vec) & mask);
    assign evt_is_rise = |rise_vec;

    assign evt_valid = (count_reg != '0);
    assign fifo_full = (count_reg == (AW + 1)'(FIFO_DEPTH));
    assign pop       = evt_valid && evt_ready;
    assign push      = push_req && (!fifo_full || pop);
    assign drop      = push_req && fifo_full && !pop;
    assign {evt_chan, evt_rise} = mem_reg[rd_ptr_reg];
    assign ovf       = ovf_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                mem_reg[wr_ptr_reg] <= {ptr_reg, evt_is_rise};
                wr_ptr_reg          <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (drop) begin
            ovf_reg <= 1'b1;
        end else if (ovf_clr) begin
            ovf_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_glitch_filter_scan.sv
// Bench for glitch_filter_scan: directed scenarios plus random traffic, every cycle
// checked against an event-level model of the filter and its event queue.
module tb_glitch_filter_scan;

    localparam int N    = 4;
    localparam int L    = 2;
    localparam int D    = 4;
    localparam int CMAX = (1 << L) - 1;

    logic         clk         = 1'b0;
    logic         rst         = 1'b1;
    logic [N-1:0] pin_iob_reg = '1;
    logic         en          = 1'b0;
    logic [N-1:0] mask        = '0;
    logic [N-1:0] val;
    logic         evt_valid;
    logic         evt_ready   = 1'b0;
    logic [1:0]   evt_chan;
    logic         evt_rise;
    logic         ovf;
    logic         ovf_clr     = 1'b0;

    glitch_filter_scan #(.N(N), .L(L), .FIFO_DEPTH(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .pin_iob_reg (pin_iob_reg),
        .en          (en),
        .mask        (mask),
        .val         (val),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_chan    (evt_chan),
        .evt_rise    (evt_rise),
        .ovf         (ovf),
        .ovf_clr     (ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int chan;
        bit rise;
    } evt_t;

    int           m_cnt [N];
    bit           m_st  [N];
    int           m_ptr;
    logic [N-1:0] m_hist [$];
    evt_t         m_q [$];
    bit           m_ovf;

    int nvec = 0;
    int nmis = 0;
    int seen;
    int seen_ok;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = CMAX;
            m_st[i]  = 1'b1;
        end
        m_ptr = 0;
        m_hist.delete();
        m_hist.push_back({N{1'b1}});
        m_hist.push_back({N{1'b1}});
        m_q.delete();
        m_ovf = 1'b0;
    endtask

    // Advance one clock and apply the same edge to the model; returns 1 time unit later.
    task automatic tick();
        logic [N-1:0] s;
        bit pop, evt, rise, drop;
        int i;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            s = m_hist.pop_front();
            m_hist.push_back(pin_iob_reg);
            pop  = (m_q.size() > 0) && evt_ready;
            evt  = 1'b0;
            rise = 1'b0;
            drop = 1'b0;
            i    = m_ptr;
            if (en) begin
                if (s[i] && m_cnt[i] < CMAX) m_cnt[i]++;
                else if (!s[i] && m_cnt[i] > 0) m_cnt[i]--;
                if (m_st[i] && m_cnt[i] == 0) begin
                    m_st[i] = 1'b0; evt = 1'b1; rise = 1'b0;
                end else if (!m_st[i] && m_cnt[i] == CMAX) begin
                    m_st[i] = 1'b1; evt = 1'b1; rise = 1'b1;
                end
                m_ptr = (m_ptr + 1) % N;
            end
            if (pop) void'(m_q.pop_front());
            if (evt && mask[i]) begin
                if (m_q.size() < D) m_q.push_back('{chan: i, rise: rise});
                else drop = 1'b1;
            end
            if (drop) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
        end
        #1;
    endtask

    function automatic logic [8:0] exp_word();
        logic [N-1:0] v;
        logic [2:0]   h;
        for (int i = 0; i < N; i++) v[i] = m_st[i];
        h = 3'b000;
        if (m_q.size() > 0) h = {2'(m_q[0].chan), m_q[0].rise};
        return {v, (m_q.size() > 0), h, m_ovf};
    endfunction

    function automatic logic [8:0] obs_word();
        return {val, evt_valid, (evt_valid ? {evt_chan, evt_rise} : 3'b000), ovf};
    endfunction

    task automatic test_reset();
        model_reset();
        rst = 1'b1;
        en = 1'b1;
        pin_iob_reg = 4'b0101;
        repeat (3) tick();
        nvec++;
        if ({val, evt_valid, evt_chan, evt_rise, ovf} !== {4'hF, 1'b0, 2'b00, 1'b0, 1'b0}) begin
            nmis++;
            $display("FAIL reset_held got=%b want=%b", {val, evt_valid, evt_chan, evt_rise, ovf}, 9'b1111_0_00_0_0);
        end
        en = 1'b0;
        pin_iob_reg = '1;
        rst = 1'b0;
        tick();
        nvec++;
        if ({val, evt_valid, evt_chan, evt_rise, ovf} !== {4'hF, 1'b0, 2'b00, 1'b0, 1'b0}) begin
            nmis++;
            $display("FAIL reset_release got=%b want=%b", {val, evt_valid, evt_chan, evt_rise, ovf}, 9'b1111_0_00_0_0);
        end
    endtask

    task automatic test_fall();
        en = 1'b1; mask = '1; evt_ready = 1'b1;
        pin_iob_reg[0] = 1'b0;
        seen = 0; seen_ok = 0;
        for (int c = 0; c < 24; c++) begin
            tick();
            nvec++;
            if (obs_word() !== exp_word()) begin
                nmis++;
                $display("FAIL fall c=%0d got=%b want=%b", c, obs_word(), exp_word());
            end
            if (evt_valid && evt_ready) begin
                seen++;
                if (evt_chan == 2'd0 && !evt_rise) seen_ok++;
            end
        end
        nvec++;
        if (seen !== 1 || seen_ok !== 1 || val !== 4'b1110) begin
            nmis++;
            $display("FAIL fall_event got=%0d/%0d val=%b want=1/1 val=1110", seen, seen_ok, val);
        end
    endtask

    task automatic test_glitch();
        pin_iob_reg[1] = 1'b0;
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            if (c == 5) pin_iob_reg[1] = 1'b1;
            tick();
            nvec++;
            if (obs_word() !== exp_word()) begin
                nmis++;
                $display("FAIL glitch c=%0d got=%b want=%b", c, obs_word(), exp_word());
            end
            if (evt_valid && evt_ready) seen++;
        end
        nvec++;
        if (seen !== 0 || val !== 4'b1110) begin
            nmis++;
            $display("FAIL glitch_filtered events=%0d val=%b want=0 val=1110", seen, val);
        end
    endtask

    task automatic test_overflow();
        evt_ready = 1'b0;
        pin_iob_reg = 4'b0001;
        for (int c = 0; c < 48; c++) begin
            if (c == 24) pin_iob_reg[1] = 1'b1;
            tick();
            nvec++;
            if (obs_word() !== exp_word()) begin
                nmis++;
                $display("FAIL ovf_fill c=%0d got=%b want=%b", c, obs_word(), exp_word());
            end
        end
        nvec++;
        if (ovf !== 1'b1 || evt_valid !== 1'b1) begin
            nmis++;
            $display("FAIL ovf_set ovf=%b valid=%b want=1 1", ovf, evt_valid);
        end
        evt_ready = 1'b1;
        seen = evt_valid ? 1 : 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            nvec++;
            if (obs_word() !== exp_word()) begin
                nmis++;
                $display("FAIL drain c=%0d got=%b want=%b", c, obs_word(), exp_word());
            end
            if (c < 3 && evt_valid) seen++;
        end
        nvec++;
        if (seen !== 4 || evt_valid !== 1'b0) begin
            nmis++;
            $display("FAIL drain_b2b got=%0d valid=%b want=4 valid=0", seen, evt_valid);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        nvec++;
        if (ovf !== 1'b0) begin
            nmis++;
            $display("FAIL ovf_clr got=%b want=0", ovf);
        end
    endtask

    task automatic test_mask();
        pin_iob_reg = '1;
        for (int c = 0; c < 72; c++) begin
            if (c == 24) begin
                mask = 4'b1011; pin_iob_reg[2] = 1'b0; seen = 0;
            end
            if (c == 48) begin
                nvec++;
                if (val[2] !== 1'b0 || seen !== 0 || ovf !== 1'b0) begin
                    nmis++;
                    $display("FAIL mask_drop val2=%b events=%0d ovf=%b want=0 0 0", val[2], seen, ovf);
                end
                mask = '1; pin_iob_reg[2] = 1'b1; seen = 0; seen_ok = 0;
            end
            tick();
            nvec++;
            if (obs_word() !== exp_word()) begin
                nmis++;
                $display("FAIL mask c=%0d got=%b want=%b", c, obs_word(), exp_word());
            end
            if (evt_valid && evt_ready) begin
                seen++;
                if (evt_chan == 2'd2 && evt_rise) seen_ok++;
            end
        end
        nvec++;
        if (seen !== 1 || seen_ok !== 1) begin
            nmis++;
            $display("FAIL mask_rise got=%0d/%0d want=1/1", seen, seen_ok);
        end
    endtask

    task automatic test_freeze();
        pin_iob_reg[3] = 1'b0;
        seen = 0;
        for (int c = 0; c < 50; c++) begin
            en = !(c >= 6 && c < 26);
            tick();
            nvec++;
            if (obs_word() !== exp_word()) begin
                nmis++;
                $display("FAIL freeze c=%0d got=%b want=%b", c, obs_word(), exp_word());
            end
            if (c == 25) begin
                nvec++;
                if (val !== 4'hF) begin
                    nmis++;
                    $display("FAIL freeze_hold got=%b want=1111", val);
                end
            end
            if (evt_valid && evt_ready && evt_chan == 2'd3 && !evt_rise) seen++;
        end
        en = 1'b1;
        nvec++;
        if (seen !== 1 || val[3] !== 1'b0) begin
            nmis++;
            $display("FAIL freeze_event got=%0d val3=%b want=1 0", seen, val[3]);
        end
    endtask

    task automatic test_async_reset();
        evt_ready = 1'b0;
        pin_iob_reg = 4'b1001;
        for (int c = 0; c < 29; c++) begin
            if (c == 24) pin_iob_reg[0] = 1'b0;
            tick();
            nvec++;
            if (obs_word() !== exp_word()) begin
                nmis++;
                $display("FAIL arst_fill c=%0d got=%b want=%b", c, obs_word(), exp_word());
            end
        end
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        nvec++;
        if ({val, evt_valid, evt_chan, evt_rise, ovf} !== {4'hF, 1'b0, 2'b00, 1'b0, 1'b0}) begin
            nmis++;
            $display("FAIL arst_now got=%b want=%b", {val, evt_valid, evt_chan, evt_rise, ovf}, 9'b1111_0_00_0_0);
        end
        tick();
        rst = 1'b0;
        pin_iob_reg = '1;
        evt_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 24; c++) begin
            tick();
            nvec++;
            if (obs_word() !== exp_word()) begin
                nmis++;
                $display("FAIL arst_after c=%0d got=%b want=%b", c, obs_word(), exp_word());
            end
            if (evt_valid) seen++;
        end
        nvec++;
        if (seen !== 0) begin
            nmis++;
            $display("FAIL arst_stale got=%0d want=0", seen);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            en        = ($urandom_range(0, 3) != 0);
            evt_ready = ($urandom_range(0, 2) == 0);
            ovf_clr   = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 15) == 0) mask = N'($urandom);
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 19) == 0) pin_iob_reg[b] = ~pin_iob_reg[b];
            end
            tick();
            nvec++;
            if (obs_word() !== exp_word()) begin
                nmis++;
                $display("FAIL random c=%0d got=%b want=%b", c, obs_word(), exp_word());
            end
        end
    endtask

    initial begin
        test_reset();
        test_fall();
        test_glitch();
        test_overflow();
        test_mask();
        test_freeze();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
